// File: rtl/select_net_seq_pkg.sv
// Shared Huffman build definitions: node frame layout, sizes and the
// sequencer state encoding used by the select-network pass sequencer.
package select_net_seq_pkg;

  localparam int NODE_W     = 36;
  localparam int WEIGHT_W   = 27;
  localparam int NUM_W      = 9;
  localparam int SYM_W      = 8;
  localparam int LEAF_DEPTH = 256;

  // Node frame fields: {1'b0, symbol, weight}
  localparam int WEIGHT_LSB = 0;
  localparam int WEIGHT_MSB = 26;
  localparam int SYM_LSB    = 27;
  localparam int SYM_MSB    = 34;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // Build a leaf node frame from its symbol number and weight.
  function automatic logic [NODE_W-1:0] make_frame(input logic [SYM_W-1:0]    sym,
                                                   input logic [WEIGHT_W-1:0] weight);
    return {1'b0, sym, weight};
  endfunction

endpackage

// File: rtl/select_net_seq_if.sv
// Bus bundle between the sort-pass sequencer and its surroundings: control
// handshake, histogram RAM read port, select network port and sorted-node
// RAM write port. master = sequencer side, slave = environment side.
interface select_net_seq_if;
  import select_net_seq_pkg::*;

  logic                start;
  logic                busy;
  logic                done;
  logic                error;
  logic [NUM_W-1:0]    nz_count;

  logic                freq_rd_en;
  logic [SYM_W-1:0]    freq_rd_addr;
  logic [WEIGHT_W-1:0] freq_rd_data;

  logic                net_wr;
  logic [NODE_W-1:0]   net_in;
  logic [NODE_W-1:0]   net_out;
  logic                net_valid;

  logic                sort_wr_en;
  logic [SYM_W-1:0]    sort_wr_addr;
  logic [NODE_W-1:0]   sort_wr_data;

  modport master (
    input  start, freq_rd_data, net_out, net_valid,
    output busy, done, error, nz_count,
           freq_rd_en, freq_rd_addr,
           net_wr, net_in,
           sort_wr_en, sort_wr_addr, sort_wr_data
  );

  modport slave (
    output start, freq_rd_data, net_out, net_valid,
    input  busy, done, error, nz_count,
           freq_rd_en, freq_rd_addr,
           net_wr, net_in,
           sort_wr_en, sort_wr_addr, sort_wr_data
  );

endinterface

// File: rtl/select_net_seq.sv
// Sort-pass sequencer for the 256-entry select network. Streams the
// histogram into the network as contiguous node frames, collects the
// minimum-first outputs into the sorted-node RAM, counts non-zero symbols
// and raises a sticky stall flag if the network stops producing outputs.
module select_net_seq
  import select_net_seq_pkg::*;
#(
  parameter int DEPTH   = LEAF_DEPTH,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstN,
  select_net_seq_if.master bus
);

  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [SYM_W-1:0]  LAST_ADDR = SYM_W'(DEPTH - 1);
  localparam logic [NUM_W-1:0]  WR_FULL   = NUM_W'(DEPTH);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT);

  state_t             state;
  logic [SYM_W-1:0]   addr_d;    // read address delayed to line up with read data
  logic [NUM_W-1:0]   wr_cnt;    // sorted entries written this pass (0..DEPTH)
  logic [IDLE_W-1:0]  idle_cnt;  // cycles since last net_valid in COLLECT

  // Frame is only driven while the strobe is up so the bus idles at zero.
  assign bus.net_in = bus.net_wr ? make_frame(addr_d, bus.freq_rd_data)
                                 : {NODE_W{1'b0}};

  // Sequencer FSM, frame delay stage, counters and all registered outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= ST_IDLE;
      addr_d           <= {SYM_W{1'b0}};
      wr_cnt           <= {NUM_W{1'b0}};
      idle_cnt         <= {IDLE_W{1'b0}};
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.nz_count     <= {NUM_W{1'b0}};
      bus.freq_rd_en   <= 1'b0;
      bus.freq_rd_addr <= {SYM_W{1'b0}};
      bus.net_wr       <= 1'b0;
      bus.sort_wr_en   <= 1'b0;
      bus.sort_wr_addr <= {SYM_W{1'b0}};
      bus.sort_wr_data <= {NODE_W{1'b0}};
    end else begin
      // Read-to-frame delay: data arrives one cycle after the read strobe.
      bus.net_wr     <= bus.freq_rd_en;
      addr_d         <= bus.freq_rd_addr;
      bus.sort_wr_en <= 1'b0;
      bus.done       <= 1'b0;

      if (bus.net_wr && (bus.freq_rd_data != {WEIGHT_W{1'b0}})) begin
        bus.nz_count <= bus.nz_count + 9'd1;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            state            <= ST_LOAD;
            bus.busy         <= 1'b1;
            bus.error        <= 1'b0;
            bus.freq_rd_en   <= 1'b1;
            bus.freq_rd_addr <= {SYM_W{1'b0}};
            bus.nz_count     <= {NUM_W{1'b0}};
            wr_cnt           <= {NUM_W{1'b0}};
          end
        end

        ST_LOAD: begin
          if (bus.freq_rd_addr == LAST_ADDR) begin
            bus.freq_rd_en   <= 1'b0;
            bus.freq_rd_addr <= {SYM_W{1'b0}};
            state            <= ST_DRAIN;
          end else begin
            bus.freq_rd_addr <= bus.freq_rd_addr + 8'd1;
          end
        end

        ST_DRAIN: begin
          state    <= ST_COLLECT;
          idle_cnt <= {IDLE_W{1'b0}};
        end

        ST_COLLECT: begin
          if (wr_cnt == WR_FULL) begin
            // Final write is on the bus this cycle; finish the pass.
            state    <= ST_DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else if (bus.net_valid) begin
            bus.sort_wr_en   <= 1'b1;
            bus.sort_wr_addr <= wr_cnt[SYM_W-1:0];
            bus.sort_wr_data <= bus.net_out;
            wr_cnt           <= wr_cnt + 9'd1;
            idle_cnt         <= {IDLE_W{1'b0}};
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt  <= IDLE_SAT;
            bus.error <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= ST_ERR;
          end else begin
            idle_cnt <= idle_cnt + {{(IDLE_W-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state          <= ST_IDLE;
          bus.busy       <= 1'b0;
          bus.freq_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_select_net_seq.sv
// Bench for the select-network sort-pass sequencer: histogram RAM model,
// behavioural select-network stub, sorted RAM model and a pass table.
module tb_select_net_seq;
  import select_net_seq_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  select_net_seq_if bus();

  select_net_seq #(.DEPTH(256), .TIMEOUT(64)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.master)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Cycle index: read at the falling edge it names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Histogram RAM: one-cycle read latency.
  logic [26:0] freq_mem [256];
  logic [26:0] ram_q;
  always @(posedge clk) if (bus.freq_rd_en) ram_q <= freq_mem[bus.freq_rd_addr];
  assign bus.freq_rd_data = ram_q;

  // Sorted-node RAM.
  logic [35:0] sort_mem [256];
  always @(posedge clk) if (bus.sort_wr_en) sort_mem[bus.sort_wr_addr] <= bus.sort_wr_data;

  // Select network stub: absorbs 256 frames, then emits the smallest
  // remaining weight (lowest symbol on ties) with random gaps.
  logic [35:0] stub_frames [256];
  bit          stub_taken  [256];
  int          stub_in, stub_out, stub_wait;
  int          stub_gap, stub_limit;
  logic        stub_clear, spur;
  logic [35:0] stub_q;
  logic        stub_nv;
  assign bus.net_out   = stub_q;
  assign bus.net_valid = stub_nv | spur;

  // Network model state update.
  always @(posedge clk or negedge rstN) begin
    int best;
    if (!rstN || stub_clear) begin
      stub_in <= 0; stub_out <= 0; stub_wait <= 0; stub_nv <= 1'b0; stub_q <= 36'd0;
      for (int i = 0; i < 256; i++) stub_taken[i] <= 1'b0;
    end else begin
      stub_nv <= 1'b0;
      if (bus.net_wr && stub_in < 256) begin
        stub_frames[bus.net_in[34:27]] <= bus.net_in;
        stub_in <= stub_in + 1;
        if (stub_in == 255) stub_wait <= 2;
      end else if (stub_in == 256 && stub_out < stub_limit) begin
        if (stub_wait > 0) begin
          stub_wait <= stub_wait - 1;
        end else begin
          best = -1;
          for (int i = 0; i < 256; i++)
            if (!stub_taken[i] && (best < 0 || stub_frames[i][26:0] < stub_frames[best][26:0]))
              best = i;
          stub_q           <= stub_frames[best];
          stub_nv          <= 1'b1;
          stub_taken[best] <= 1'b1;
          stub_out         <= stub_out + 1;
          stub_wait        <= int'($urandom_range(stub_gap, 0));
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"}, 64'({bus.busy, bus.done, bus.error, bus.nz_count, bus.freq_rd_en,
                            bus.freq_rd_addr, bus.net_wr, bus.sort_wr_en, bus.sort_wr_addr}), 64'd0);
    chk({nm, "_net_in"}, 64'(bus.net_in), 64'd0);
    chk({nm, "_sort_data"}, 64'(bus.sort_wr_data), 64'd0);
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 256; i++) begin
      case (pat)
        0:       freq_mem[i] = 27'(255 - i);
        1:       freq_mem[i] = 27'd0;
        2:       freq_mem[i] = (i == 65) ? 27'd10 : ((i == 66) ? 27'd3 : 27'd0);
        3:       freq_mem[i] = ($urandom_range(3, 0) == 0) ? 27'd0 : 27'($urandom_range(15, 1));
        default: freq_mem[i] = ($urandom_range(7, 0) == 0) ? 27'd0 : 27'($urandom);
      endcase
    end
  endtask

  // Position of symbol j in a minimum-first ordering (ties by symbol).
  function automatic int rank_of(input int j);
    int r = 0;
    for (int k = 0; k < 256; k++)
      if (freq_mem[k] < freq_mem[j] || (freq_mem[k] == freq_mem[j] && k < j)) r++;
    return r;
  endfunction

  typedef struct {
    int pat; int gap; int limit; int mode; int nz; bit exp_done;
  } pass_t;
  typedef struct {
    int pass_idx; int addr; logic [35:0] frame;
  } point_t;

  pass_t  passes [8];
  point_t points [7];

  task automatic run_pass(input int p);
    int t0 = 0, tail = 0, n_rd = 0, n_fr = 0, n_wr = 0, n_done = 0;
    int rd_err = 0, fr_err = 0, wa_err = 0, sort_err = 0;
    int first_rd = 0, last_rd = 0, first_wr = 0, last_wr = 0, last_sw = 0;
    int done_cyc = 0, err_cyc = -1, nz_exp = 0, exp_wr, mode, r;
    bit finished = 1'b0, aborted = 1'b0;
    logic [7:0] sym;

    mode       = passes[p].mode;
    stub_gap   = passes[p].gap;
    stub_limit = passes[p].limit;
    fill(passes[p].pat);
    for (int i = 0; i < 256; i++) if (freq_mem[i] != 27'd0) nz_exp++;
    if (passes[p].nz >= 0) nz_exp = passes[p].nz;
    exp_wr = (passes[p].limit < 256) ? passes[p].limit : 256;

    stub_clear = 1'b1;
    @(negedge clk);
    stub_clear = 1'b0;
    t0 = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk($sformatf("p%0d_busy_err_after_start", p), 64'({bus.busy, bus.error}), 64'd2);

    for (int k = 0; k < 4000 && !finished; k++) begin
      if (bus.freq_rd_en) begin
        if (n_rd == 0) first_rd = cyc;
        last_rd = cyc;
        if (bus.freq_rd_addr != 8'(n_rd)) rd_err++;
        n_rd++;
      end
      if (bus.net_wr) begin
        sym = bus.net_in[34:27];
        if (n_fr == 0) first_wr = cyc;
        last_wr = cyc;
        if (sym != 8'(n_fr) || bus.net_in[26:0] != freq_mem[sym] || bus.net_in[35]) fr_err++;
        n_fr++;
      end
      if (bus.sort_wr_en) begin
        if (bus.sort_wr_addr != 8'(n_wr)) wa_err++;
        n_wr++;
        last_sw = cyc;
      end
      if (bus.done) begin n_done++; done_cyc = cyc; end
      if (bus.error && err_cyc < 0) err_cyc = cyc;

      if (mode == 3 && n_wr == 50) begin
        rstN = 1'b0;
        #1;
        chk_zero($sformatf("p%0d_async_reset", p));
        aborted  = 1'b1;
        finished = 1'b1;
      end
      if (n_done > 0 || err_cyc >= 0) begin
        tail++;
        if (tail > 4) finished = 1'b1;
      end

      bus.start = !aborted && ((mode == 1 && (cyc == t0 + 50 || cyc == t0 + 300)) ||
                               (mode == 2 && bus.net_valid && stub_out == 256));
      spur = (mode == 1 && cyc == t0 + 60);
      if (!finished) @(negedge clk);
    end
    bus.start = 1'b0;
    spur      = 1'b0;

    if (!aborted) begin
      chk($sformatf("p%0d_pass_completed", p), 64'(finished), 64'd1);
      chk($sformatf("p%0d_rd_window", p), {32'(first_rd - t0), 32'(last_rd - t0)}, {32'd1, 32'd256});
      chk($sformatf("p%0d_rd_count_err", p), {32'(n_rd), 32'(rd_err)}, {32'd256, 32'd0});
      chk($sformatf("p%0d_frame_window", p), {32'(first_wr - t0), 32'(last_wr - t0)}, {32'd2, 32'd257});
      chk($sformatf("p%0d_frames_err", p), {32'(n_fr), 32'(fr_err)}, {32'd256, 32'd0});
      chk($sformatf("p%0d_writes_err", p), {32'(n_wr), 32'(wa_err)}, {32'(exp_wr), 32'd0});
      if (passes[p].exp_done) begin
        chk($sformatf("p%0d_done_cnt_lag", p), {32'(n_done), 32'(done_cyc - last_sw)}, {32'd1, 32'd1});
        chk($sformatf("p%0d_end_flags", p), 64'({bus.busy, bus.done, bus.error}), 64'd0);
      end else begin
        // Error lands TIMEOUT cycles after the last sorted write.
        chk($sformatf("p%0d_stall_cnt_lag", p), {32'(n_done), 32'(err_cyc - last_sw)}, {32'd0, 32'd64});
        chk($sformatf("p%0d_end_flags", p), 64'({bus.busy, bus.done, bus.error}), 64'd1);
      end
      chk($sformatf("p%0d_nz_count", p), 64'(bus.nz_count), 64'(nz_exp));
      for (int j = 0; j < 256; j++) begin
        r = rank_of(j);
        if (r < exp_wr && sort_mem[r] !== {1'b0, 8'(j), freq_mem[j]}) sort_err++;
      end
      chk($sformatf("p%0d_sorted_order_errs", p), 64'(sort_err), 64'd0);
      for (int i = 0; i < 7; i++)
        if (points[i].pass_idx == p)
          chk($sformatf("p%0d_sorted_addr%0d", p, points[i].addr),
              64'(sort_mem[points[i].addr]), 64'(points[i].frame));
    end
  endtask

  initial begin
    //            pat gap limit mode  nz  done
    passes[0] = '{0,  0,  256,  0,   255, 1'b1};  // descending weights
    passes[1] = '{1,  2,  256,  0,   0,   1'b1};  // all zero
    passes[2] = '{2,  1,  256,  0,   2,   1'b1};  // only 'A' and 'B'
    passes[3] = '{3,  3,  100,  0,   -1,  1'b0};  // network stalls after 100
    passes[4] = '{4,  2,  256,  1,   -1,  1'b1};  // starts/spurious valid while busy
    passes[5] = '{3,  1,  256,  2,   -1,  1'b1};  // start with final valid
    passes[6] = '{4,  2,  256,  3,   -1,  1'b1};  // reset mid-collect
    passes[7] = '{0,  3,  256,  0,   255, 1'b1};  // clean pass after reset
    points[0] = '{0, 0,   {1'b0, 8'd255, 27'd0}};
    points[1] = '{0, 255, {1'b0, 8'd0,   27'd255}};
    points[2] = '{0, 100, {1'b0, 8'd155, 27'd100}};
    points[3] = '{2, 254, {1'b0, 8'd66,  27'd3}};
    points[4] = '{2, 255, {1'b0, 8'd65,  27'd10}};
    points[5] = '{2, 0,   {1'b0, 8'd0,   27'd0}};
    points[6] = '{7, 255, {1'b0, 8'd0,   27'd255}};

    rstN = 1'b0; bus.start = 1'b0; spur = 1'b0; stub_clear = 1'b0;
    stub_gap = 0; stub_limit = 256;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rstN = 1'b1;
    @(negedge clk);

    for (int p = 0; p < 8; p++) begin
      run_pass(p);
      if (p == 0) begin
        // A valid while parked in DONE must not write.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("valid_in_done_ignored", 64'({bus.sort_wr_en, bus.busy}), 64'd0);
      end
      if (passes[p].mode == 3) begin
        repeat (3) @(negedge clk);
        chk_zero("held_in_reset");
        rstN = 1'b1;
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
